ha_serial_seq: RTL

HA_SERIAL_SEQ -- requirements
Module: ha_serial_seq

---
 rtl/ha_seq_pkg.sv | 20 ++
 rtl/ha_cell.sv | 12 +
 rtl/ha_serial_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ha_seq_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Subtract support in the top level is enabled by defining HA_SEQ_SUB_EN.
package ha_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned WidthDefault = 8;

  // Bit counter width for a given operand width; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned CntWidthDefault = cnt_width(WidthDefault);

endpackage

// File: rtl/ha_cell.sv
// Half adder cell; two of these plus an OR form one full-adder bit slice.
module ha_cell (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/ha_serial_seq.sv
// Bit-serial adder, LSB first, one bit per cycle with valid/ready handshakes.
// Define HA_SEQ_SUB_EN to make in_sub select A + ~B + 1; otherwise in_sub is ignored.
module ha_serial_seq
  import ha_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;

  logic a_bit;
  logic b_bit;
  logic start_carry;
  logic ha0_sum;
  logic ha0_carry;
  logic sum_bit;
  logic ha1_carry;
  logic carry_next;

`ifdef HA_SEQ_SUB_EN
  logic sub_q;

  assign b_bit       = b_q[cnt_q] ^ sub_q;
  assign start_carry = in_sub;
`else
  logic unused_sub;

  assign unused_sub  = in_sub;
  assign b_bit       = b_q[cnt_q];
  assign start_carry = 1'b0;
`endif

  assign a_bit = a_q[cnt_q];

  ha_cell u_ha0 (
    .a_i     (a_bit),
    .b_i     (b_bit),
    .sum_o   (ha0_sum),
    .carry_o (ha0_carry)
  );

  ha_cell u_ha1 (
    .a_i     (ha0_sum),
    .b_i     (carry_q),
    .sum_o   (sum_bit),
    .carry_o (ha1_carry)
  );

  assign carry_next = ha0_carry | ha1_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef HA_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            cnt_q   <= '0;
            carry_q <= start_carry;
`ifdef HA_SEQ_SUB_EN
            sub_q   <= in_sub;
`endif
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[cnt_q] <= sum_bit;
          carry_q      <= carry_next;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            cout_q  <= carry_next;
            state_q <= StDone;
          end
        end
        StDone: begin
          // Result is cleared on consumption so out_sum reads 0 while idle.
          if (out_ready) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
